// File: rtl/match_serializer.sv
// Match serializer: captures per-note match triggers with a signed timing error and
// drains them round-robin through a show-ahead FIFO. Option: MATCH_SERIALIZER_DT_SAT_EN.
module match_serializer #(
  parameter int NUM_NOTES  = 37,
  parameter int TIME_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = $clog2(NUM_NOTES),
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TIME_W-1:0]             song_time,
  input  logic [NUM_NOTES-1:0]          match_trigger,
  input  logic [NUM_NOTES*TIME_W-1:0]   match_time,
  output logic                          match_valid,
  input  logic                          match_ready,
  output logic [IDX_W-1:0]              match_note,
  output logic [TIME_W-1:0]             match_dt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              overrun_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + IDX_W + 1;
  localparam logic [IDX_W:0]  NOTES_X = (IDX_W+1)'(NUM_NOTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);
  localparam logic [PTR_W:0]  DEPTH_X = (PTR_W+1)'(FIFO_DEPTH);

  // song_time - match_time evaluated at TIME_W+1 bits, reduced back to TIME_W.
  function automatic logic [TIME_W-1:0] calc_dt(input logic [TIME_W-1:0] st,
                                                input logic [TIME_W-1:0] mt);
`ifdef MATCH_SERIALIZER_DT_SAT_EN
    logic [TIME_W:0] diff;
    diff = {1'b0, st} - {1'b0, mt};
    if (diff[TIME_W] != diff[TIME_W-1])
      calc_dt = diff[TIME_W] ? {1'b1, {(TIME_W-1){1'b0}}} : {1'b0, {(TIME_W-1){1'b1}}};
    else
      calc_dt = diff[TIME_W-1:0];
`else
    calc_dt = st - mt;
`endif
  endfunction

  logic [NUM_NOTES-1:0]      pend_q, pend_d;
  logic [TIME_W-1:0]         dt_q [NUM_NOTES];
  logic [TIME_W-1:0]         dt_d [NUM_NOTES];
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W+TIME_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]          ovr_q, ovr_d;

  logic                      any_pend;
  logic [IDX_W-1:0]          gnt_idx;
  logic [IDX_W:0]            cand;
  logic                      full, pop, push;
  logic [IDX_W:0]            n_ov;
  logic [SUM_W-1:0]          ov_sum;
  logic [IDX_W+TIME_W-1:0]   head;

  // Round-robin search starting at ptr_q, wrapping at NUM_NOTES-1.
  always_comb begin
    any_pend = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    for (int k = 0; k < NUM_NOTES; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= NOTES_X) cand = cand - NOTES_X;
      if (!any_pend && pend_q[cand[IDX_W-1:0]]) begin
        any_pend = 1'b1;
        gnt_idx  = cand[IDX_W-1:0];
      end
    end
  end

  // Handshake: the head transfers on an edge where match_valid && match_ready;
  // while match_valid && !match_ready the head and outputs stay stable.
  assign match_valid = (cnt_q != '0);
  assign full        = (cnt_q == DEPTH_X);
  assign pop         = match_valid && match_ready;
  assign push        = any_pend && (!full || pop);

  always_comb begin
    pend_d = pend_q;
    n_ov   = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      dt_d[i] = dt_q[i];
      if (push && gnt_idx == IDX_W'(i)) pend_d[i] = 1'b0;
      if (match_trigger[i]) begin
        pend_d[i] = 1'b1;
        dt_d[i]   = calc_dt(song_time, match_time[i*TIME_W +: TIME_W]);
        // Retriggering a slot that is leaving this cycle is a fresh entry, not an overrun.
        if (pend_q[i] && !(push && gnt_idx == IDX_W'(i))) n_ov = n_ov + (IDX_W+1)'(1);
      end
    end
    ov_sum = SUM_W'(ovr_q) + SUM_W'(n_ov);
    ovr_d  = (|ov_sum[SUM_W-1:CNT_W]) ? '1 : ov_sum[CNT_W-1:0];

    ptr_d = ptr_q;
    if (push) ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);

    wr_d  = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = pop  ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int i = 0; i < NUM_NOTES; i++) dt_q[i] <= '0;
      ptr_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < NUM_NOTES; i++) dt_q[i] <= dt_d[i];
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {gnt_idx, dt_q[gnt_idx]};
  end

  assign head        = mem_q[rd_q];
  assign match_note  = match_valid ? head[IDX_W+TIME_W-1:TIME_W] : '0;
  assign match_dt    = match_valid ? head[TIME_W-1:0] : '0;
  assign fifo_count  = cnt_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_match_serializer.sv
// Directed bench for match_serializer (default parameters: 37 notes, 16-bit time, depth 8).
module tb_match_serializer;

  localparam int N  = 37;
  localparam int TW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [TW-1:0]     song_time = '0;
  logic [N-1:0]      match_trigger = '0;
  logic [N*TW-1:0]   match_time = '0;
  logic              match_valid;
  logic              match_ready = 1'b0;
  logic [5:0]        match_note;
  logic [TW-1:0]     match_dt;
  logic [3:0]        fifo_count;
  logic [7:0]        overrun_cnt;

  int n_vec = 0;
  int n_err = 0;

  match_serializer dut (
    .clk(clk), .rst_n(rst_n), .song_time(song_time), .match_trigger(match_trigger),
    .match_time(match_time), .match_valid(match_valid), .match_ready(match_ready),
    .match_note(match_note), .match_dt(match_dt), .fifo_count(fifo_count),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mt(input int note, input logic [TW-1:0] v);
    match_time[note*TW +: TW] = v;
  endtask

  // Trigger is held across exactly one rising edge; returns just after the next falling edge.
  task automatic pulse(input logic [N-1:0] mask);
    match_trigger = mask;
    @(negedge clk);
    match_trigger = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic chk_head(input string tag, input int note, input logic [TW-1:0] dt);
    chk({tag, "_valid"}, 32'(match_valid), 32'd1);
    chk({tag, "_note"}, 32'(match_note), 32'(note));
    chk({tag, "_dt"}, 32'(match_dt), 32'(dt));
  endtask

  logic [N-1:0] m;

  initial begin
    // 1: reset state and idle after release
    #2;
    chk("rst_valid", 32'(match_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    chk("rst_note", 32'(match_note), 32'd0);
    chk("rst_dt", 32'(match_dt), 32'd0);
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("idle_valid", 32'(match_valid), 32'd0);
      chk("idle_count", 32'(fifo_count), 32'd0);
      chk("idle_ovr", 32'(overrun_cnt), 32'd0);
    end

    // 2: single match, positive then negative dt
    match_ready = 1'b1;
    song_time = 16'd1000;
    set_mt(5, 16'd990);
    m = '0; m[5] = 1'b1;
    pulse(m);
    chk("single_pre_valid", 32'(match_valid), 32'd0);
    step(1);
    chk_head("single_pos", 5, 16'd10);
    chk("single_count", 32'(fifo_count), 32'd1);
    step(1);
    chk("single_drained", 32'(match_valid), 32'd0);
    set_mt(5, 16'd1010);
    pulse(m);
    step(1);
    chk_head("single_neg", 5, 16'hFFF6);
    step(1);
    chk("single_neg_drained", 32'(match_valid), 32'd0);

    // 3: simultaneous notes 0, 3, 36 from pointer 0
    do_reset();
    set_mt(0, 16'd999);
    set_mt(3, 16'd998);
    set_mt(36, 16'd997);
    m = '0; m[0] = 1'b1; m[3] = 1'b1; m[36] = 1'b1;
    pulse(m);
    step(1);
    chk_head("simul_a", 0, 16'd1);
    step(1);
    chk_head("simul_b", 3, 16'd2);
    step(1);
    chk_head("simul_c", 36, 16'd3);
    step(1);
    chk("simul_empty", 32'(match_valid), 32'd0);
    // pointer wrapped to 0: note 1 must win over note 36
    set_mt(1, 16'd996);
    m = '0; m[1] = 1'b1; m[36] = 1'b1;
    pulse(m);
    step(1);
    chk_head("wrap_a", 1, 16'd4);
    step(1);
    chk_head("wrap_b", 36, 16'd3);
    step(1);
    chk("wrap_empty", 32'(match_valid), 32'd0);

    // 4: backpressure, 10 notes into a depth-8 FIFO
    match_ready = 1'b0;
    m = '0;
    for (int n = 10; n < 20; n++) begin
      set_mt(n, 16'(1000 - n));
      m[n] = 1'b1;
    end
    pulse(m);
    step(10);
    chk("bp_count_full", 32'(fifo_count), 32'd8);
    step(3);
    chk("bp_count_hold", 32'(fifo_count), 32'd8);
    chk_head("bp_head_hold", 10, 16'd10);
    match_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk_head("bp_drain", 10 + j, 16'(10 + j));
      step(1);
    end
    chk("bp_empty", 32'(match_valid), 32'd0);
    chk("bp_ovr", 32'(overrun_cnt), 32'd0);

    // 5: overrun on note 7 while the FIFO is full
    match_ready = 1'b0;
    m = '0;
    for (int n = 20; n < 28; n++) begin
      set_mt(n, 16'd995);
      m[n] = 1'b1;
    end
    pulse(m);
    step(10);
    chk("ovr_full", 32'(fifo_count), 32'd8);
    m = '0; m[7] = 1'b1;
    set_mt(7, 16'd996);
    pulse(m);
    set_mt(7, 16'd994);
    pulse(m);
    step(1);
    chk("ovr_cnt", 32'(overrun_cnt), 32'd1);
    chk("ovr_count_hold", 32'(fifo_count), 32'd8);
    match_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk_head("ovr_drain", 20 + j, 16'd5);
      step(1);
    end
    chk_head("ovr_note7", 7, 16'd6);
    step(1);
    chk("ovr_once", 32'(match_valid), 32'd0);
    step(3);
    chk("ovr_once_later", 32'(match_valid), 32'd0);
    chk("ovr_cnt_after", 32'(overrun_cnt), 32'd1);

    // 6: difference extremes, then reset mid-drain
    song_time = 16'hFFFF;
    set_mt(0, 16'h0000);
    m = '0; m[0] = 1'b1;
    pulse(m);
    step(1);
`ifdef MATCH_SERIALIZER_DT_SAT_EN
    chk_head("sat_pos", 0, 16'h7FFF);
`else
    chk_head("wrap_pos", 0, 16'hFFFF);
`endif
    step(1);
    song_time = 16'h0000;
    set_mt(0, 16'hFFFF);
    pulse(m);
    step(1);
`ifdef MATCH_SERIALIZER_DT_SAT_EN
    chk_head("sat_neg", 0, 16'h8000);
`else
    chk_head("wrap_neg", 0, 16'h0001);
`endif
    step(1);

    match_ready = 1'b0;
    song_time = 16'd1000;
    m = '0;
    for (int n = 1; n < 4; n++) begin
      set_mt(n, 16'd1000);
      m[n] = 1'b1;
    end
    pulse(m);
    step(4);
    chk("mid_count", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(match_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_note", 32'(match_note), 32'd0);
    chk("mid_rst_dt", 32'(match_dt), 32'd0);
    chk("mid_rst_ovr", 32'(overrun_cnt), 32'd0);
    step(2);
    rst_n = 1'b1;
    match_ready = 1'b1;
    step(4);
    chk("post_rst_valid", 32'(match_valid), 32'd0);
    chk("post_rst_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/match_serializer.md
Name: match_serializer

Overview:
- Parametrised successor to the score-chain match serializer. Accepts per-note match triggers from NUM_NOTES note checkers and computes a signed timing error per match. Serializes matches into a FIFO with a valid/ready output toward the scoring block.
- Unlike the single-register predecessor:
  - no match is lost when several notes hit in the same cycle;
  - dt is signed-correct;
  - the note index travels with each match.

Parameters:
- NUM_NOTES, 37, number of note channels (>=2).
- TIME_W, 16, width of song_time, match_time entries and match_dt.
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2).
- IDX_W, $clog2(NUM_NOTES), width of the note index.
- CNT_W, 8, width of the overrun counter.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- song_time  in  TIME_W  current song time, unsigned.
- match_trigger  in  NUM_NOTES  one-cycle pulse per note on a match.
- match_time  in  NUM_NOTES*TIME_W  note target time; note i occupies bits [i*TIME_W +: TIME_W].
- match_valid  out  1  FIFO head valid.
- match_ready  in  1  consumer accepts the head when match_valid && match_ready.
- match_note  out  IDX_W  note index of the head entry.
- match_dt  out  TIME_W  signed dt of the head entry (song_time - match_time at capture).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun_cnt  out  CNT_W  count of pending-slot overwrites; saturates at all-ones.

Behaviour:
- Reset:
  - All outputs are 0.
  - All pending slots are cleared.
  - The arbiter pointer is 0.
  - The FIFO is empty.
  - Reset may assert at any time. Every in-flight match is discarded; there are no partial outputs after release.
- Capture stage:
  - Each note has a pending slot {pend, dt}.
  - On an edge where match_trigger[i]=1, the slot stores pend=1 and dt = reduce(song_time - match_time[i]).
  - The subtraction is done at TIME_W+1 bits and treated as signed. reduce() is defined under Optional Feature.
- Arbitration:
  - Each cycle, if any pend=1 and the FIFO is not full (or is being popped this cycle), grant exactly one note.
  - The grant is round-robin: search from the pointer upward, wrapping at NUM_NOTES-1 to 0.
  - The granted {i, dt} is written into the FIFO and pend[i] is cleared. The pointer becomes (i+1) mod NUM_NOTES.
  - If nothing is granted, the pointer holds.
- Simultaneous events on note i:
  - Trigger while slot i is being granted: the old entry goes to the FIFO and the new entry becomes pending. Not an overrun.
  - Trigger while slot i is pending and not granted: dt is overwritten and overrun_cnt increments, saturating.
  - Multiple notes triggering in one cycle: all are captured and drained one per cycle in round-robin order.
- FIFO:
  - Show-ahead: the head is presented on match_note/match_dt while match_valid=1.
  - match_valid is 1 iff fifo_count != 0.
  - Full and no pop: no grant, and the pending slots hold. There is no drop at the FIFO.
  - Simultaneous push and pop when full is allowed, and the count is unchanged.
  - Pop when empty is ignored.
  - The head and outputs are stable while match_valid && !match_ready.
- Latency:
  - A trigger sampled at edge k sets the pending slot at k.
  - The earliest grant and FIFO write is at edge k+1.
  - match_valid rises after edge k+1 when the FIFO was empty and there is no competing pending note.
- Pointer wrap: the index is NUM_NOTES-1, then 0. It never exceeds NUM_NOTES-1.

Optional Feature:
- Macro: MATCH_SERIALIZER_DT_SAT_EN.
- Defined: reduce() saturates the signed (TIME_W+1)-bit difference to the signed TIME_W range.
  - Max is 2^(TIME_W-1)-1; min is -2^(TIME_W-1).
  - Example for TIME_W=16: 0x7FFF / 0x8000.
- Undefined: reduce() keeps the low TIME_W bits (two's-complement wrap).

Test Plan (all scenarios use TIME_W=16):
1. Reset release, no triggers -> match_valid=0, fifo_count=0, overrun_cnt=0 held for 20 cycles.
2. Single match: song_time=1000, trigger note 5 with match_time[5]=990, match_ready=1 -> match_valid=1 two edges later, match_note=5, match_dt=10. Repeat with match_time=1010 -> match_dt=0xFFF6 (-10).
3. Simultaneous: notes 0, 3 and 36 trigger in the same cycle, pointer=0, ready=1 -> three consecutive valid cycles with note order 0, 3, 36. Pointer ends at 0 (wrap).
4. Backpressure: ready=0, trigger 10 distinct notes with FIFO_DEPTH=8 -> fifo_count stops at 8 and 2 slots stay pending. Raise ready -> all 10 delivered, no loss, overrun_cnt=0.
5. Overrun: ready=0 with the FIFO full, note 7 triggers twice, dt 4 then 6 -> overrun_cnt=1; note 7 is later delivered once with dt=6.
6. Saturation: song_time=0xFFFF, match_time=0x0000 -> match_dt=0x7FFF with MATCH_SERIALIZER_DT_SAT_EN defined, 0xFFFF without. Also assert rst_n mid-drain -> outputs 0 immediately and the FIFO is empty after release.
